// File: rtl/io_bridge_if.sv
// io_bridge_if: CPU memory-stage bus as seen by the I/O bridge.
//   cpu_addr  : byte address from the memory stage
//   cpu_wen   : store strobe, one cycle per store
//   cpu_wdata : store data
//   cpu_rdata : load data, returned combinationally in the same cycle
// master = CPU side, slave = bridge side.
interface io_bridge_if;
    logic [31:0] cpu_addr;
    logic        cpu_wen;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_addr,
        output cpu_wen,
        output cpu_wdata,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_addr,
        input  cpu_wen,
        input  cpu_wdata,
        output cpu_rdata
    );
endinterface

// File: rtl/io_bridge.sv
// io_bridge: memory-mapped bridge between the CPU memory stage, data RAM and
// a small peripheral block (LEDs, switches, buttons, 8-digit 7-seg display).
// Ports:
//   clk, rst       : system clock, synchronous active-high reset
//   cpu            : CPU bus (io_bridge_if.slave), read data is combinational
//   dram_addr/wen/wdata, dram_rdata : data RAM port (word addressed)
//   sw, btn        : asynchronous switch/button pins (two-flop synchronised)
//   led            : registered LED drive
//   seg_en, seg_out: registered, active-low digit enables and segments
// Peripheral map (0xFFFFFxxx is I/O space, everything else is RAM):
//   F000 display W/R, F060 LED W/R, F070 switches R, F078 buttons R.
module io_bridge #(
    parameter int unsigned DRAM_AW  = 14,
    parameter int unsigned SCAN_DIV = 2000
) (
    input  logic               clk,
    input  logic               rst,
    io_bridge_if.slave         cpu,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_wen,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         seg_en,
    output logic [7:0]         seg_out
);

    localparam logic [31:0] ADDR_DISP = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN  = 32'hFFFF_F078;
    localparam logic [15:0] DIV_LAST  = 16'(SCAN_DIV - 1);

    logic        is_io;

    logic [31:0] disp_q, disp_d;
    logic [23:0] led_q, led_d;
    logic [23:0] sw_m_q, sw_s_q;
    logic [4:0]  btn_m_q, btn_s_q;
    logic [15:0] div_cnt_q, div_cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  seg_en_q, seg_en_d;
    logic [7:0]  seg_out_q, seg_out_d;
    logic [3:0]  nibble;

    function automatic logic [7:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 8'hC0;
            4'h1: hex7 = 8'hF9;
            4'h2: hex7 = 8'hA4;
            4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;
            4'h5: hex7 = 8'h92;
            4'h6: hex7 = 8'h82;
            4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;
            4'h9: hex7 = 8'h90;
            4'hA: hex7 = 8'h88;
            4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;
            4'hD: hex7 = 8'hA1;
            4'hE: hex7 = 8'h86;
            default: hex7 = 8'h8E;
        endcase
    endfunction

    // RAM path: address and data always pass through; only the strobe is gated.
    assign is_io      = (cpu.cpu_addr[31:12] == 20'hFFFFF);
    assign dram_addr  = cpu.cpu_addr[DRAM_AW+1:2];
    assign dram_wdata = cpu.cpu_wdata;
    assign dram_wen   = cpu.cpu_wen & ~is_io;

    // Combinational read mux.
    always_comb begin
        cpu.cpu_rdata = '0;
        if (!is_io) begin
            cpu.cpu_rdata = dram_rdata;
        end else begin
            case (cpu.cpu_addr)
                ADDR_DISP: cpu.cpu_rdata = disp_q;
                ADDR_LED:  cpu.cpu_rdata = {8'h00, led_q};
                ADDR_SW:   cpu.cpu_rdata = {8'h00, sw_s_q};
                ADDR_BTN:  cpu.cpu_rdata = {27'h0, btn_s_q};
                default:   cpu.cpu_rdata = '0;
            endcase
        end
    end

    // Peripheral register writes.
    always_comb begin
        disp_d = disp_q;
        led_d  = led_q;
        if (cpu.cpu_wen) begin
            if (cpu.cpu_addr == ADDR_DISP) disp_d = cpu.cpu_wdata;
            if (cpu.cpu_addr == ADDR_LED)  led_d  = cpu.cpu_wdata[23:0];
        end
    end

    // Scanner and display outputs. The outputs are computed from the current
    // idx/disp, so they lag the scan position by exactly one cycle.
    always_comb begin
        div_cnt_d = div_cnt_q + 16'd1;
        idx_d     = idx_q;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end
        nibble    = disp_q[{idx_q, 2'b00} +: 4];
        seg_en_d  = ~(8'b1 << idx_q);
        seg_out_d = hex7(nibble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q    <= '0;
            led_q     <= '0;
            sw_m_q    <= '0;
            sw_s_q    <= '0;
            btn_m_q   <= '0;
            btn_s_q   <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            seg_en_q  <= '1;
            seg_out_q <= '1;
        end else begin
            disp_q    <= disp_d;
            led_q     <= led_d;
            sw_m_q    <= sw;
            sw_s_q    <= sw_m_q;
            btn_m_q   <= btn;
            btn_s_q   <= btn_m_q;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign led     = led_q;
    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: randomized self-checking bench for io_bridge against a
// behavioural model (register values, pin history, and scan position derived
// from the number of clock edges since reset release).
module tb_io_bridge;

    localparam int unsigned SD = 4;

    logic        clk;
    logic        rst;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    io_bridge_if bus ();

    io_bridge #(.DRAM_AW(14), .SCAN_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (bus.slave),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .seg_en     (seg_en),
        .seg_out    (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] m_disp;
    logic [23:0] m_led;
    logic [23:0] sw_hist [2];   // pin value seen at the last edge / the one before
    logic [4:0]  btn_hist [2];
    int unsigned m_run;         // edges since reset release
    logic [7:0]  m_seg_en, m_seg_out;

    function automatic logic [31:0] exp_rdata(input logic [31:0] a, input logic [31:0] dr);
        if (a[31:12] != 20'hFFFFF) return dr;
        case (a)
            32'hFFFF_F000: return m_disp;
            32'hFFFF_F060: return {8'h00, m_led};
            32'hFFFF_F070: return {8'h00, sw_hist[1]};
            32'hFFFF_F078: return {27'h0, btn_hist[1]};
            default:       return 32'h0;
        endcase
    endfunction

    // One clock cycle with the currently driven inputs: check the
    // combinational paths, advance the model, then check registered outputs.
    task automatic cycle();
        int unsigned digit;
        logic [31:0] a;
        a = bus.cpu_addr;
        #1;
        check("dram_wen",   {31'h0, dram_wen}, {31'h0, bus.cpu_wen && (a[31:12] != 20'hFFFFF)});
        check("dram_addr",  {18'h0, dram_addr}, {18'h0, a[15:2]});
        check("dram_wdata", dram_wdata, bus.cpu_wdata);
        check("cpu_rdata",  bus.cpu_rdata, exp_rdata(a, dram_rdata));
        if (rst) begin
            m_disp = 0; m_led = 0; m_run = 0;
            sw_hist[0] = 0; sw_hist[1] = 0; btn_hist[0] = 0; btn_hist[1] = 0;
            m_seg_en = 8'hFF; m_seg_out = 8'hFF;
        end else begin
            digit     = (m_run / SD) % 8;
            m_seg_en  = ~(8'h01 << digit);
            m_seg_out = HEX[(m_disp >> (4 * digit)) & 32'hF];
            if (bus.cpu_wen && a == 32'hFFFF_F000) m_disp = bus.cpu_wdata;
            if (bus.cpu_wen && a == 32'hFFFF_F060) m_led  = bus.cpu_wdata[23:0];
            sw_hist[1]  = sw_hist[0];  sw_hist[0]  = sw;
            btn_hist[1] = btn_hist[0]; btn_hist[0] = btn;
            m_run++;
        end
        @(posedge clk);
        #1;
        check("led",     {8'h0, led},      {8'h0, m_led});
        check("seg_en",  {24'h0, seg_en},  {24'h0, m_seg_en});
        check("seg_out", {24'h0, seg_out}, {24'h0, m_seg_out});
    endtask

    task automatic op(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [31:0] dr);
        bus.cpu_addr  = a;
        bus.cpu_wen   = w;
        bus.cpu_wdata = wd;
        dram_rdata    = dr;
        cycle();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 7))
            0: a = 32'hFFFF_F000;
            1: a = 32'hFFFF_F060;
            2: a = 32'hFFFF_F070;
            3: a = 32'hFFFF_F078;
            4: a = 32'hFFFF_F100;
            5: a = 32'hFFFF_F000 | ($urandom & 32'hFFF);
            default: begin
                a = $urandom;
                if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
            end
        endcase
        return a;
    endfunction

    initial begin
        rst = 1'b1; sw = '0; btn = '0; dram_rdata = '0;
        bus.cpu_addr = '0; bus.cpu_wen = 1'b0; bus.cpu_wdata = '0;
        m_disp = 0; m_led = 0; m_run = 0; m_seg_en = 8'hFF; m_seg_out = 8'hFF;
        sw_hist[0] = 0; sw_hist[1] = 0; btn_hist[0] = 0; btn_hist[1] = 0;
        @(posedge clk); #1;

        // Reset for 2 cycles, with a store presented that must be discarded.
        op(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF, 32'h0);
        op(32'h0000_0000, 1'b0, 32'h0, 32'h0);
        check("rst_led", {8'h0, led}, 32'h0);
        check("rst_seg_en", {24'h0, seg_en}, 32'hFF);
        rst = 1'b0;
        op(32'h0000_0000, 1'b0, 32'h0, 32'h0);
        check("first_seg_en", {24'h0, seg_en}, 32'hFE);
        check("first_seg_out", {24'h0, seg_out}, 32'hC0);

        // RAM store and load.
        op(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0);
        op(32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF);
        // LED store, readback, ignored store to switches.
        op(32'hFFFF_F060, 1'b1, 32'hFFA5_A5A5, 32'h1234_5678);
        check("led_a5", {8'h0, led}, 32'h00A5_A5A5);
        op(32'hFFFF_F060, 1'b0, 32'h0, 32'h0);
        op(32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF, 32'h0);
        // Switch / button synchronisers.
        sw = 24'h123456; btn = 5'b10001;
        op(32'hFFFF_F070, 1'b0, 32'h0, 32'h0);
        op(32'hFFFF_F070, 1'b0, 32'h0, 32'h0);
        op(32'hFFFF_F070, 1'b0, 32'h0, 32'h0);
        op(32'hFFFF_F078, 1'b0, 32'h0, 32'h0);
        op(32'hFFFF_F100, 1'b0, 32'h0, 32'hFFFF_FFFF);

        // Full scan of 0x12345678 from a fresh reset, then reset at idx 5.
        rst = 1'b1; op(32'h0, 1'b0, 32'h0, 32'h0); rst = 1'b0;
        op(32'hFFFF_F000, 1'b1, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 8 * SD + 4; i++) op(32'hFFFF_F000, 1'b0, 32'h0, 32'h0);
        rst = 1'b1; op(32'h0, 1'b0, 32'h0, 32'h0); rst = 1'b0;
        op(32'hFFFF_F000, 1'b1, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 5 * SD - 1; i++) op(32'hFFFF_F000, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        op(32'hFFFF_F000, 1'b0, 32'h0, 32'h0);
        check("midscan_rst_en", {24'h0, seg_en}, 32'hFF);
        op(32'hFFFF_F000, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        op(32'hFFFF_F000, 1'b0, 32'h0, 32'h0);
        check("restart_seg_out", {24'h0, seg_out}, 32'hC0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) sw  = 24'($urandom);
            if ($urandom_range(0, 7) == 0) btn = 5'($urandom);
            op(pick_addr(), 1'($urandom), $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped bus bridge directly downstream of the CPU's memory stage; consumes the CPU's address, write-enable and write-data outputs and returns read data.
- Splits accesses between data RAM and a small peripheral block: LEDs, switches, buttons and an 8-digit 7-segment display.
- The CPU samples read data in the same cycle as the address, so the read path is combinational. Peripheral state, switch synchronisers and the display scanner are sequential.

Parameters:
- DRAM_AW, 14: word-address width presented to data RAM.
- SCAN_DIV, 2000: clock cycles each display digit stays enabled; legal range 2..65535.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_addr  in  32  byte address from memory stage
- cpu_wen  in  1  store strobe, one cycle per store
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, combinational
- dram_addr  out  DRAM_AW  word address, cpu_addr[DRAM_AW+1:2]
- dram_wen  out  1  RAM write enable
- dram_wdata  out  32  RAM write data, equal to cpu_wdata
- dram_rdata  in  32  RAM read data, combinational from dram_addr
- sw  in  24  asynchronous switch inputs
- btn  in  5  asynchronous button inputs
- led  out  24  LED drive, registered
- seg_en  out  8  digit enables, active-low, registered
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered

Behaviour:
- Address decode:
  - is_io = (cpu_addr[31:12] == 20'hFFFFF).
  - All other addresses are RAM.
- Peripheral map (full-address compare):
  - F000: display register, W/R
  - F060: LED, W/R
  - F070: switches, R
  - F078: buttons, R
- RAM path:
  - dram_wen = cpu_wen & ~is_io.
  - dram_addr and dram_wdata pass through unconditionally.
- Reads (combinational):
  - cpu_rdata = dram_rdata when ~is_io.
  - F000 returns disp_reg.
  - F060 returns {8'b0, led}.
  - F070 returns {8'b0, sw_s}.
  - F078 returns {27'b0, btn_s}.
  - Any other peripheral address returns 0.
- Writes (take effect at the clock edge where cpu_wen=1):
  - F000 loads disp_reg <= cpu_wdata.
  - F060 loads led <= cpu_wdata[23:0].
  - Writes to F070, F078 or unmapped peripheral addresses are ignored, with no RAM write.
- Synchronisers:
  - sw and btn each pass through a two-flop synchroniser; sw_s and btn_s are the second stage.
  - A pin change is visible on cpu_rdata exactly 2 edges later.
- Scanner:
  - div_cnt counts 0..SCAN_DIV-1.
  - On the cycle div_cnt == SCAN_DIV-1: div_cnt <= 0 and idx <= idx+1; idx is 3 bits and wraps 7 -> 0.
- Display outputs (registered every cycle, one cycle of latency):
  - seg_en <= ~(8'b1 << idx).
  - seg_out <= hex7(disp_reg[4*idx+3 -: 4]).
  - A display write mid-digit appears on seg_out within 2 edges; scan timing is unaffected.
- hex7 table, 0..F:
  - 0-7: C0 F9 A4 B0 99 92 82 F8
  - 8-F: 80 90 88 83 C6 A1 86 8E
  - dp always off.
- Reset, any cycle, including mid-scan and mid-store:
  - disp_reg=0, led=0, sw_s=btn_s and both sync stages = 0, div_cnt=0, idx=0.
  - seg_en=8'hFF, seg_out=8'hFF.
  - A store presented during rst is discarded for peripherals; dram_wen stays combinational and is not gated by rst.
- First cycle after reset release:
  - seg_en=FE.
  - seg_out=C0.

Test Plan:
- rst=1 for 2 cycles, then release -> during reset led=0, seg_en=FF, seg_out=FF; one edge after release seg_en=FE, seg_out=C0.
- Store cpu_addr=0x00000010, wdata=0xDEADBEEF, wen=1 -> dram_wen=1, dram_addr=4; same address with dram_rdata=0xDEADBEEF -> cpu_rdata=0xDEADBEEF.
- Store 0xFFFFF060 with 0xFFA5A5A5 -> led=0xA5A5A5 next edge, dram_wen=0; load F060 -> 0x00A5A5A5; store F070 -> no state change, dram_wen=0.
- sw=0x123456 applied -> load F070 returns 0 after 1 edge and 0x00123456 after 2 edges; btn=5'b10001 -> load F078 returns 0x11 after 2 edges; load 0xFFFFF100 -> 0.
- SCAN_DIV=4, store F000=0x12345678 -> digit 0 shows 8 (80, en FE) for 4 cycles, then 7 (F8, en FD), ... digit 7 shows 1 (F9, en 7F), then wraps to FE.
- SCAN_DIV=4, assert rst while idx=5 -> next edge seg_en=FF, disp_reg=0; after release scanning restarts at idx 0 with seg_out=C0.
